// File: rtl/future_round_ctrl.sv
// future_round_ctrl: round sequencer for the FUTURE 64-bit block cipher.
// Holds the cipher state. Steps it through key whitening and then NUM_ROUNDS rounds
// of the external combinational datapath. Returns the ciphertext over valid/ready.
// Optional feature: define FUTURE_CTRL_ABORT_EN to add a synchronous `abort` input.
// That input drops an in-flight block and returns the controller to IDLE.
module future_round_ctrl #(
  parameter int STATE_W    = 64,
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [STATE_W-1:0] pt_data,
  output logic [STATE_W-1:0] dp_state,
  input  logic [STATE_W-1:0] dp_result,
  output logic               dp_whiten,
  output logic               dp_last,
  output logic [RND_W-1:0]   dp_round,
  output logic               key_step,
  output logic               ct_valid,
  input  logic               ct_ready,
  output logic [STATE_W-1:0] ct_data,
  output logic               busy
`ifdef FUTURE_CTRL_ABORT_EN
  ,
  input  logic               abort
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WHITEN = 2'd1,
    S_ROUND  = 2'd2,
    S_DONE   = 2'd3
  } fsm_t;

  localparam logic [RND_W-1:0] FIRST_RND = RND_W'(1);
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS);

  fsm_t               fsm_r;
  logic [STATE_W-1:0] state_r;
  logic [RND_W-1:0]   ctr_r;
  logic               abort_s;

`ifdef FUTURE_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // The datapath and the ciphertext port both see the state register directly.
  assign dp_state = state_r;
  assign ct_data  = state_r;

  // Sequencer FSM. Every output is registered from the state being entered,
  // so the outputs line up with the cycle that state is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r     <= S_IDLE;
      state_r   <= '0;
      ctr_r     <= '0;
      pt_ready  <= 1'b1;
      busy      <= 1'b0;
      ct_valid  <= 1'b0;
      key_step  <= 1'b0;
      dp_whiten <= 1'b0;
      dp_last   <= 1'b0;
      dp_round  <= '0;
    end else if (abort_s && (fsm_r != S_IDLE)) begin
      // A dropped block leaves no partial state behind.
      fsm_r     <= S_IDLE;
      state_r   <= '0;
      ctr_r     <= '0;
      pt_ready  <= 1'b1;
      busy      <= 1'b0;
      ct_valid  <= 1'b0;
      key_step  <= 1'b0;
      dp_whiten <= 1'b0;
      dp_last   <= 1'b0;
      dp_round  <= '0;
    end else begin
      case (fsm_r)
        S_IDLE: begin
          if (pt_valid) begin
            fsm_r     <= S_WHITEN;
            state_r   <= pt_data;
            ctr_r     <= '0;
            pt_ready  <= 1'b0;
            busy      <= 1'b1;
            key_step  <= 1'b1;
            dp_whiten <= 1'b1;
            dp_last   <= 1'b0;
            dp_round  <= '0;
          end else begin
            ctr_r <= '0;
          end
        end
        S_WHITEN: begin
          fsm_r     <= S_ROUND;
          state_r   <= dp_result;
          ctr_r     <= FIRST_RND;
          key_step  <= 1'b1;
          dp_whiten <= 1'b0;
          dp_last   <= (FIRST_RND == LAST_RND);
          dp_round  <= FIRST_RND;
        end
        S_ROUND: begin
          state_r <= dp_result;
          if (ctr_r == LAST_RND) begin
            // The counter stops at the final round. It is cleared again on the way back to IDLE.
            fsm_r    <= S_DONE;
            key_step <= 1'b0;
            dp_last  <= 1'b0;
            dp_round <= '0;
            ct_valid <= 1'b1;
          end else begin
            ctr_r    <= ctr_r + FIRST_RND;
            key_step <= 1'b1;
            dp_last  <= ((ctr_r + FIRST_RND) == LAST_RND);
            dp_round <= ctr_r + FIRST_RND;
          end
        end
        S_DONE: begin
          if (ct_ready) begin
            fsm_r    <= S_IDLE;
            ctr_r    <= '0;
            ct_valid <= 1'b0;
            busy     <= 1'b0;
            pt_ready <= 1'b1;
          end else begin
            ct_valid <= 1'b1;
          end
        end
        default: begin
          fsm_r     <= S_IDLE;
          state_r   <= '0;
          ctr_r     <= '0;
          pt_ready  <= 1'b1;
          busy      <= 1'b0;
          ct_valid  <= 1'b0;
          key_step  <= 1'b0;
          dp_whiten <= 1'b0;
          dp_last   <= 1'b0;
          dp_round  <= '0;
        end
      endcase
    end
  end

endmodule
